// File: rtl/ip_lpm_pkg.sv
// Shared types and helpers for the pipelined longest-prefix-match lookup table.
// Entry fields are sized for the widest supported key; instances use the low bits.
package ip_lpm_pkg;

    localparam int KEY_W_MAX  = 64;
    localparam int DATA_W_MAX = 128;
    localparam int PLEN_W     = 7;

    typedef struct packed {
        logic [KEY_W_MAX-1:0]  key;
        logic [KEY_W_MAX-1:0]  mask;
        logic [DATA_W_MAX-1:0] data;
        logic                  valid;
        logic [PLEN_W-1:0]     plen;
    } entry_t;

    // Ceiling log2, never below 1 so a one-entry table still has an address bit.
    function automatic int lpm_log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ip_lpm_pl_prio_sel.sv
// Longest-prefix priority selector: picks the matching entry with the largest
// prefix length, lowest index on ties.
module lpm_prio_sel
    import ip_lpm_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 5,
    parameter int PW = PLEN_W
) (
    input  logic [N-1:0]    match,
    input  logic [N*PW-1:0] plen_flat,
    output logic [AW-1:0]   idx,
    output logic [PW-1:0]   plen,
    output logic            hit
);

    // Strict greater-than keeps the earlier (lower) index when lengths tie.
    always_comb begin
        idx  = '0;
        plen = '0;
        hit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (match[i] && (!hit || (plen_flat[i*PW +: PW] > plen))) begin
                hit  = 1'b1;
                idx  = AW'(i);
                plen = plen_flat[i*PW +: PW];
            end
        end
    end

endmodule

// File: rtl/ip_lpm_pl.sv
// Pipelined longest-prefix-match route table with read/write maintenance ports.
// Define IP_LPM_HIT_CNT_EN to add a saturating 32-bit hit counter per entry.
module ip_lpm_pl
    import ip_lpm_pkg::*;
#(
    parameter int KEY_WIDTH    = 32,
    parameter int NUM_QUEUES   = 8,
    parameter int LUT_DEPTH    = 32,
    parameter int DEFAULT_PORT = 0,
    localparam int AW = lpm_log2(LUT_DEPTH),
    localparam int DW = NUM_QUEUES + KEY_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  lookup_req,
    input  logic [KEY_WIDTH-1:0]  lookup_key,
    output logic                  lookup_ack,
    output logic                  lookup_hit,
    output logic [NUM_QUEUES-1:0] lookup_port,
    output logic [KEY_WIDTH-1:0]  lookup_next_hop,

    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_ack,
    output logic [KEY_WIDTH-1:0]  rd_key,
    output logic [KEY_WIDTH-1:0]  rd_mask,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic [31:0]           rd_hit_cnt,

    input  logic                  wr_req,
    input  logic [AW-1:0]         wr_addr,
    output logic                  wr_ack,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic [KEY_WIDTH-1:0]  wr_mask,
    input  logic [DW-1:0]         wr_data,
    input  logic                  wr_valid
);

    localparam logic [NUM_QUEUES-1:0] DEF_PORT = NUM_QUEUES'(DEFAULT_PORT);

    entry_t                   tbl [LUT_DEPTH];
    entry_t                   wr_entry;
    entry_t                   win;
    logic                     wr_in_range;
    logic                     rd_in_range;
    logic [KEY_W_MAX-1:0]     key_ext;
    logic [LUT_DEPTH-1:0]     match;
    logic [LUT_DEPTH*PLEN_W-1:0] plen_flat;
    logic [31:0]              cnt_rd;

    logic                     s1_valid;
    logic [KEY_WIDTH-1:0]     s1_key;
    logic [LUT_DEPTH-1:0]     s1_match;

    logic [AW-1:0]            sel_idx;
    logic [PLEN_W-1:0]        sel_plen;
    logic                     sel_hit;

    logic                     s2_valid;
    logic [KEY_WIDTH-1:0]     s2_key;
    logic [AW-1:0]            s2_idx;
    logic [PLEN_W-1:0]        s2_plen;
    logic                     s2_hit;

    logic [NUM_QUEUES-1:0]    win_port;
    logic [KEY_WIDTH-1:0]     win_nh;

    // Prefix length is fixed at write time so the lookup path never counts bits.
    always_comb begin
        wr_entry       = '0;
        wr_entry.key   = KEY_W_MAX'(wr_key);
        wr_entry.mask  = KEY_W_MAX'(wr_mask);
        wr_entry.data  = DATA_W_MAX'(wr_data);
        wr_entry.valid = wr_valid;
        wr_entry.plen  = PLEN_W'($countones(wr_mask));
        wr_in_range    = 32'(wr_addr) < 32'(LUT_DEPTH);
        rd_in_range    = 32'(rd_addr) < 32'(LUT_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                tbl[i].valid <= 1'b0;
            end
        end else if (wr_req && wr_in_range) begin
            tbl[wr_addr] <= wr_entry;
        end
    end

    always_comb begin
        key_ext   = KEY_W_MAX'(lookup_key);
        match     = '0;
        plen_flat = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            match[i] = tbl[i].valid && (((key_ext ^ tbl[i].key) & tbl[i].mask) == '0);
            plen_flat[i*PLEN_W +: PLEN_W] = tbl[i].plen;
        end
    end

    lpm_prio_sel #(
        .N  (LUT_DEPTH),
        .AW (AW),
        .PW (PLEN_W)
    ) u_prio_sel (
        .match     (s1_match),
        .plen_flat (plen_flat),
        .idx       (sel_idx),
        .plen      (sel_plen),
        .hit       (sel_hit)
    );

    always_comb begin
        win      = tbl[s2_idx];
        win_port = win.data[KEY_WIDTH +: NUM_QUEUES];
        win_nh   = win.data[KEY_WIDTH-1:0];
    end

    // A zero stored next hop means "deliver directly", so the key is passed through.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid        <= 1'b0;
            s2_valid        <= 1'b0;
            lookup_ack      <= 1'b0;
            lookup_hit      <= 1'b0;
            lookup_port     <= DEF_PORT;
            lookup_next_hop <= '0;
        end else begin
            s1_valid   <= lookup_req;
            s1_key     <= lookup_key;
            s1_match   <= match;

            s2_valid   <= s1_valid;
            s2_key     <= s1_key;
            s2_idx     <= sel_idx;
            s2_plen    <= sel_plen;
            s2_hit     <= sel_hit;

            lookup_ack <= s2_valid;
            if (s2_valid) begin
                lookup_hit <= s2_hit;
                if (s2_hit) begin
                    lookup_port     <= win_port;
                    lookup_next_hop <= (win_nh == '0) ? s2_key : win_nh;
                end else begin
                    lookup_port     <= DEF_PORT;
                    lookup_next_hop <= s2_key;
                end
            end
        end
    end

`ifdef IP_LPM_HIT_CNT_EN
    logic [31:0] hit_cnt [LUT_DEPTH];

    // A write to the entry wins over a same-cycle increment from S3.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (wr_req && wr_in_range && (wr_addr == AW'(i))) begin
                    hit_cnt[i] <= '0;
                end else if (s2_valid && s2_hit && (s2_idx == AW'(i)) && (hit_cnt[i] != '1)) begin
                    hit_cnt[i] <= hit_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign cnt_rd = rd_in_range ? hit_cnt[rd_addr] : 32'd0;
`else
    assign cnt_rd = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack     <= 1'b0;
            wr_ack     <= 1'b0;
            rd_key     <= '0;
            rd_mask    <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_hit_cnt <= '0;
        end else begin
            rd_ack <= rd_req;
            wr_ack <= wr_req;
            if (rd_req) begin
                if (rd_in_range) begin
                    rd_key   <= tbl[rd_addr].key[KEY_WIDTH-1:0];
                    rd_mask  <= tbl[rd_addr].mask[KEY_WIDTH-1:0];
                    rd_data  <= tbl[rd_addr].data[DW-1:0];
                    rd_valid <= tbl[rd_addr].valid;
                end else begin
                    rd_key   <= '0;
                    rd_mask  <= '0;
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end
                rd_hit_cnt <= cnt_rd;
            end
        end
    end

endmodule

// File: tb/tb_ip_lpm_pl.sv
// Self-checking bench for ip_lpm_pl: directed route scenarios plus randomized
// lookups checked against a longest-prefix reference model.
module tb_ip_lpm_pl;

    localparam int KW       = 32;
    localparam int NQ       = 8;
    localparam int LD       = 24;
    localparam int AW       = 5;
    localparam int DEF_PORT = 0;

    typedef struct {
        logic [31:0] key;
        bit          hit;
        int          idx;
        logic [7:0]  port;
        logic [31:0] nh;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_req;
    logic [KW-1:0] lookup_key;
    logic          lookup_ack;
    logic          lookup_hit;
    logic [NQ-1:0] lookup_port;
    logic [KW-1:0] lookup_next_hop;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [KW-1:0] rd_key;
    logic [KW-1:0] rd_mask;
    logic [NQ+KW-1:0] rd_data;
    logic          rd_valid;
    logic [31:0]   rd_hit_cnt;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;
    logic [KW-1:0] wr_key;
    logic [KW-1:0] wr_mask;
    logic [NQ+KW-1:0] wr_data;
    logic          wr_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] m_key  [LD];
    logic [31:0] m_mask [LD];
    logic [31:0] m_nh   [LD];
    logic [31:0] m_cnt  [LD];
    logic [7:0]  m_port [LD];
    bit          m_valid[LD];

    ip_lpm_pl #(
        .KEY_WIDTH    (KW),
        .NUM_QUEUES   (NQ),
        .LUT_DEPTH    (LD),
        .DEFAULT_PORT (DEF_PORT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_req      (lookup_req),
        .lookup_key      (lookup_key),
        .lookup_ack      (lookup_ack),
        .lookup_hit      (lookup_hit),
        .lookup_port     (lookup_port),
        .lookup_next_hop (lookup_next_hop),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ack          (rd_ack),
        .rd_key          (rd_key),
        .rd_mask         (rd_mask),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_hit_cnt      (rd_hit_cnt),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_ack          (wr_ack),
        .wr_key          (wr_key),
        .wr_mask         (wr_mask),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: best = longest matching mask, lowest index on equal length.
    function automatic exp_t model_lookup(input logic [31:0] k);
        exp_t e;
        int   best;
        best  = -1;
        e.key = k;
        e.hit = 1'b0;
        e.idx = -1;
        e.due = 0;
        for (int i = 0; i < LD; i++) begin
            if (m_valid[i] && (((k ^ m_key[i]) & m_mask[i]) == 32'h0) && ($countones(m_mask[i]) > best)) begin
                best  = $countones(m_mask[i]);
                e.hit = 1'b1;
                e.idx = i;
            end
        end
        e.port = 8'(DEF_PORT);
        e.nh   = k;
        if (e.hit) begin
            e.port = m_port[e.idx];
            if (m_nh[e.idx] != 32'h0) e.nh = m_nh[e.idx];
        end
        return e;
    endfunction

    task automatic do_write(input int a, input logic [31:0] k, input logic [31:0] m,
                            input logic [7:0] p, input logic [31:0] nh, input bit v,
                            output logic ack);
        wr_addr  = a[AW-1:0];
        wr_key   = k;
        wr_mask  = m;
        wr_data  = {p, nh};
        wr_valid = v;
        wr_req   = 1'b1;
        tick();
        wr_req = 1'b0;
        ack    = wr_ack;
        if (a < LD) begin
            m_key[a]   = k;
            m_mask[a]  = m;
            m_port[a]  = p;
            m_nh[a]    = nh;
            m_valid[a] = v;
            m_cnt[a]   = 32'h0;
        end
    endtask

    task automatic do_read(input int a, output logic ack, output logic [71:0] kmd,
                           output logic v, output logic [31:0] c);
        rd_addr = a[AW-1:0];
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        ack    = rd_ack;
        kmd    = {rd_key, rd_data};
        v      = rd_valid;
        c      = rd_hit_cnt;
    endtask

    task automatic run_lookup(input logic [31:0] k, output exp_t e, output int lat);
        e          = model_lookup(k);
        lookup_key = k;
        lookup_req = 1'b1;
        tick();
        lookup_req = 1'b0;
        lat        = 1;
        while (lookup_ack !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
`ifdef IP_LPM_HIT_CNT_EN
        if (e.hit) m_cnt[e.idx]++;
`endif
    endtask

    task automatic test_reset();
        logic ack, v;
        logic [71:0] kmd;
        logic [31:0] c;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({lookup_ack, lookup_hit, lookup_port, lookup_next_hop, rd_ack, wr_ack} !== {2'b00, 8'(DEF_PORT), 32'h0, 2'b00}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ack=%b hit=%b port=%h nh=%h rd_ack=%b wr_ack=%b expected 0/0/%h/0/0/0",
                     lookup_ack, lookup_hit, lookup_port, lookup_next_hop, rd_ack, wr_ack, 8'(DEF_PORT));
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < LD; i += 7) begin
            do_read(i, ack, kmd, v, c);
            checks++;
            if ({ack, v, c} !== {1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("[TB] FAIL reset_entry%0d: got ack=%b valid=%b cnt=%0d expected 1/0/0", i, ack, v, c);
            end
        end
    endtask

    task automatic test_miss();
        exp_t e;
        int   lat;
        logic ack;
        run_lookup(32'hC0A80001, e, lat);
        checks++;
        if (lat != 3 || {lookup_hit, lookup_port, lookup_next_hop} !== {1'b0, 8'(DEF_PORT), 32'hC0A80001}) begin
            errors++;
            $display("[TB] FAIL miss_empty: got lat=%0d hit=%b port=%h nh=%h expected 3/0/%h/c0a80001",
                     lat, lookup_hit, lookup_port, lookup_next_hop, 8'(DEF_PORT));
        end
        do_write(9, 32'h0, 32'h0, 8'h10, 32'h0, 1'b1, ack);
        run_lookup(32'hC0A80001, e, lat);
        checks++;
        if (lat != 3 || {lookup_hit, lookup_port, lookup_next_hop} !== {1'b1, 8'h10, 32'hC0A80001}) begin
            errors++;
            $display("[TB] FAIL miss_default_route: got lat=%0d hit=%b port=%h nh=%h expected 3/1/10/c0a80001",
                     lat, lookup_hit, lookup_port, lookup_next_hop);
        end
        do_write(9, 32'h0, 32'h0, 8'h10, 32'h0, 1'b0, ack);
    endtask

    task automatic test_single_route();
        exp_t e;
        int   lat;
        logic ack;
        do_write(3, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0, 1'b1, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wr_ack: got %b expected 1", ack);
        end
        run_lookup(32'h0A010203, e, lat);
        checks++;
        if (lat != 3 || {lookup_hit, lookup_port, lookup_next_hop} !== {1'b1, 8'h01, 32'h0A010203}) begin
            errors++;
            $display("[TB] FAIL single_route: got lat=%0d hit=%b port=%h nh=%h expected 3/1/01/0a010203",
                     lat, lookup_hit, lookup_port, lookup_next_hop);
        end
    endtask

    task automatic test_longest_prefix();
        exp_t e;
        int   lat;
        logic ack;
        do_write(0, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0B000001, 1'b1, ack);
        do_write(5, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0, 1'b1, ack);
        run_lookup(32'h0A010203, e, lat);
        checks++;
        if ({lookup_hit, lookup_port, lookup_next_hop} !== {1'b1, 8'h04, 32'h0A010203}) begin
            errors++;
            $display("[TB] FAIL lpm_longest: got hit=%b port=%h nh=%h expected 1/04/0a010203",
                     lookup_hit, lookup_port, lookup_next_hop);
        end
        run_lookup(32'h0A020304, e, lat);
        checks++;
        if ({lookup_hit, lookup_port, lookup_next_hop} !== {1'b1, 8'h01, 32'h0B000001}) begin
            errors++;
            $display("[TB] FAIL lpm_tie_idx0_idx3: got hit=%b port=%h nh=%h expected 1/01/0b000001",
                     lookup_hit, lookup_port, lookup_next_hop);
        end
        do_write(7, 32'h14000000, 32'hFFFFFF00, 8'h02, 32'h07070707, 1'b1, ack);
        do_write(2, 32'h14000000, 32'hFFFFFF00, 8'h20, 32'h02020202, 1'b1, ack);
        run_lookup(32'h14000005, e, lat);
        checks++;
        if ({lookup_hit, lookup_port, lookup_next_hop} !== {1'b1, 8'h20, 32'h02020202}) begin
            errors++;
            $display("[TB] FAIL lpm_tie_idx2_idx7: got hit=%b port=%h nh=%h expected 1/20/02020202",
                     lookup_hit, lookup_port, lookup_next_hop);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] keys [4];
        exp_t        ex   [4];
        logic        want;
        keys[0] = 32'h0A010203;
        keys[1] = 32'hC0A80001;
        keys[2] = 32'h14000009;
        keys[3] = 32'h63000000;
        for (int j = 0; j < 4; j++) ex[j] = model_lookup(keys[j]);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                lookup_key = keys[k];
                lookup_req = 1'b1;
            end else begin
                lookup_req = 1'b0;
            end
            tick();
            want = (k >= 2 && k <= 5);
            checks++;
            if (lookup_ack !== want) begin
                errors++;
                $display("[TB] FAIL b2b_ack_cycle%0d: got %b expected %b", k, lookup_ack, want);
            end
            if (want) begin
                checks++;
                if ({lookup_hit, lookup_port, lookup_next_hop} !== {ex[k-2].hit, ex[k-2].port, ex[k-2].nh}) begin
                    errors++;
                    $display("[TB] FAIL b2b_result%0d: got hit=%b port=%h nh=%h expected %b/%h/%h",
                             k - 2, lookup_hit, lookup_port, lookup_next_hop, ex[k-2].hit, ex[k-2].port, ex[k-2].nh);
                end
`ifdef IP_LPM_HIT_CNT_EN
                if (ex[k-2].hit) m_cnt[ex[k-2].idx]++;
`endif
            end
        end
    endtask

    task automatic test_concurrency();
        logic [71:0] old_kmd, kmd;
        logic        ack, v;
        logic [31:0] c;
        exp_t        e;
        int          lat;
        old_kmd  = {m_key[3], m_port[3], m_nh[3]};
        rd_addr  = 5'd3;
        rd_req   = 1'b1;
        wr_addr  = 5'd3;
        wr_key   = 32'h0A000000;
        wr_mask  = 32'hFFFF0000;
        wr_data  = {8'h80, 32'h12345678};
        wr_valid = 1'b1;
        wr_req   = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_req = 1'b0;
        checks++;
        if ({rd_ack, wr_ack, rd_key, rd_data, rd_valid} !== {2'b11, old_kmd, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rw_same_addr: got acks=%b%b key=%h data=%h valid=%b expected 11/%h/1",
                     rd_ack, wr_ack, rd_key, rd_data, rd_valid, old_kmd);
        end
        m_key[3] = 32'h0A000000; m_mask[3] = 32'hFFFF0000; m_port[3] = 8'h80;
        m_nh[3]  = 32'h12345678; m_valid[3] = 1'b1; m_cnt[3] = 32'h0;
        do_read(3, ack, kmd, v, c);
        checks++;
        if ({kmd, rd_mask} !== {32'h0A000000, 8'h80, 32'h12345678, 32'hFFFF0000}) begin
            errors++;
            $display("[TB] FAIL rw_new_data: got %h mask=%h expected 0a0000008012345678 mask=ffff0000", kmd, rd_mask);
        end
        lookup_key = 32'h0A010203;
        lookup_req = 1'b1;
        tick();
        lookup_key = 32'hC0A80001;
        tick();
        lookup_req = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lookup_ack !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_flight_ack%0d: got %b expected 0", k, lookup_ack);
            end
            tick();
        end
        for (int i = 0; i < LD; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 32'h0;
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 2 || i == 3 || i == 5 || i == 7 || i == 9) begin
                do_read(i, ack, kmd, v, c);
                checks++;
                if (v !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_valid%0d: got %b expected 0", i, v);
                end
            end
        end
        run_lookup(32'h0A010203, e, lat);
        checks++;
        if (lat != 3 || lookup_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_table_miss: got lat=%0d hit=%b expected 3/0", lat, lookup_hit);
        end
    endtask

    task automatic test_counters();
        exp_t        e;
        int          lat;
        logic        ack, v;
        logic [71:0] kmd;
        logic [31:0] c;
        do_write(3, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0, 1'b1, ack);
        for (int n = 0; n < 5; n++) run_lookup(32'h0A000000 | 32'($urandom_range(0, 32'hFFFFFF)), e, lat);
        do_read(3, ack, kmd, v, c);
        checks++;
        if (c !== m_cnt[3]) begin
            errors++;
            $display("[TB] FAIL cnt_after_hits: got %0d expected %0d", c, m_cnt[3]);
        end
        do_write(3, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0, 1'b1, ack);
        do_read(3, ack, kmd, v, c);
        checks++;
        if (c !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cnt_rewrite_clear: got %0d expected 0", c);
        end
        lookup_key = 32'h0A7F0000;
        lookup_req = 1'b1;
        tick();
        lookup_req = 1'b0;
        tick();
        do_write(3, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0, 1'b1, ack);
        checks++;
        if ({lookup_ack, lookup_hit, ack} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL cnt_collide_acks: got ack=%b hit=%b wr_ack=%b expected 111", lookup_ack, lookup_hit, ack);
        end
        do_read(3, ack, kmd, v, c);
        checks++;
        if (c !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cnt_collide_clear: got %0d expected 0", c);
        end
    endtask

    task automatic test_out_of_range();
        exp_t        e;
        int          lat;
        logic        ack, v;
        logic [71:0] kmd;
        logic [31:0] c;
        do_write(27, 32'hC0A80000, 32'hFFFF0000, 8'h02, 32'h0, 1'b1, ack);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_wr_ack: got %b expected 1", ack);
        end
        do_read(27, ack, kmd, v, c);
        checks++;
        if ({ack, kmd, rd_mask, v, c} !== {1'b1, 72'h0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL oor_rd_zero: got ack=%b data=%h mask=%h valid=%b cnt=%0d expected 1/0/0/0/0",
                     ack, kmd, rd_mask, v, c);
        end
        run_lookup(32'hC0A80001, e, lat);
        checks++;
        if ({lookup_hit, lookup_port} !== {e.hit, e.port} || lookup_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oor_no_change: got hit=%b port=%h expected 0/%h", lookup_hit, lookup_port, e.port);
        end
        do_write(LD - 1, 32'hDEADBEEF, 32'hFFFFFFFF, 8'h40, 32'h0, 1'b1, ack);
        do_read(LD - 1, ack, kmd, v, c);
        checks++;
        if ({ack, kmd, v} !== {1'b1, 32'hDEADBEEF, 8'h40, 32'h0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL last_entry_rd: got ack=%b data=%h valid=%b expected 1/deadbeef4000000000/1", ack, kmd, v);
        end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        ack;
        int          a, len, src;
        logic [31:0] k, m;
        for (int n = 0; n < 16; n++) begin
            a   = $urandom_range(0, LD - 1);
            len = $urandom_range(0, 32);
            m   = (len == 0) ? 32'h0 : (32'hFFFFFFFF << (32 - len));
            if ($urandom_range(0, 3) == 0) m = $urandom;
            do_write(a, $urandom, m, 8'(1 << $urandom_range(0, 7)),
                     ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom, $urandom_range(0, 4) != 0, ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand_wr_ack%0d: got %b expected 1", n, ack);
            end
        end
        for (int c = 0; c < 84; c++) begin
            if (c < 80 && $urandom_range(0, 2) != 0) begin
                src = $urandom_range(0, LD - 1);
                k   = $urandom;
                if ($urandom_range(0, 1) == 1) k = (m_key[src] & m_mask[src]) | (k & ~m_mask[src]);
                e     = model_lookup(k);
                e.due = cyc + 3;
                q.push_back(e);
                lookup_key = k;
                lookup_req = 1'b1;
            end else begin
                lookup_req = 1'b0;
            end
            tick();
            if (lookup_ack === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_spurious_ack: got ack at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.due || {lookup_hit, lookup_port, lookup_next_hop} !== {e.hit, e.port, e.nh}) begin
                        errors++;
                        $display("[TB] FAIL rand_lookup key=%h: got cyc=%0d hit=%b port=%h nh=%h expected cyc=%0d %b/%h/%h",
                                 e.key, cyc, lookup_hit, lookup_port, lookup_next_hop, e.due, e.hit, e.port, e.nh);
                    end
`ifdef IP_LPM_HIT_CNT_EN
                    if (e.hit) m_cnt[e.idx]++;
`endif
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_missing_ack key=%h: got no ack at cycle %0d expected one", q[0].key, cyc);
                void'(q.pop_front());
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: got %0d outstanding expected 0", q.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        lookup_req = 1'b0;
        lookup_key = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_key     = '0;
        wr_mask    = '0;
        wr_data    = '0;
        wr_valid   = 1'b0;
        for (int i = 0; i < LD; i++) begin
            m_key[i] = 32'h0; m_mask[i] = 32'h0; m_nh[i] = 32'h0;
            m_cnt[i] = 32'h0; m_port[i] = 8'h0; m_valid[i] = 1'b0;
        end
        test_reset();
        test_miss();
        test_single_route();
        test_longest_prefix();
        test_back_to_back();
        test_concurrency();
        test_counters();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_lpm_pl.md
IP_LPM_PL -- requirements
Module: ip_lpm_pl

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 32, lookup key width.
REQ-002 SHALL have parameter NUM_QUEUES, default 8, one-hot output port width.
REQ-003 SHALL have parameter LUT_DEPTH, default 32, table entries; the address width is ceil(log2(LUT_DEPTH)), called AW.
REQ-004 SHALL have parameter DEFAULT_PORT, default 0, the one-hot port value driven on a miss.
REQ-005 SHALL have the clock and reset ports listed below:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
REQ-006 SHALL have the lookup ports listed below:
- lookup_req  in  1  single-cycle lookup strobe.
- lookup_key  in  KEY_WIDTH  destination address.
- lookup_ack  out  1  result-valid pulse.
- lookup_hit  out  1  match found.
- lookup_port  out  NUM_QUEUES  result port.
- lookup_next_hop  out  KEY_WIDTH  result next hop.
REQ-007 SHALL have the read ports listed below:
- rd_req  in  1  table read strobe.
- rd_addr  in  AW  read index.
- rd_ack  out  1  read-done pulse.
- rd_key, rd_mask  out  KEY_WIDTH each  stored key and care-mask.
- rd_data  out  NUM_QUEUES+KEY_WIDTH  {port, next hop}.
- rd_valid  out  1  entry valid.
- rd_hit_cnt  out  32  entry hit count.
REQ-008 SHALL have the write ports listed below:
- wr_req  in  1  table write strobe.
- wr_addr  in  AW  write index.
- wr_ack  out  1  write-done pulse.
- wr_key, wr_mask  in  KEY_WIDTH each  key and care-mask (1 = compare).
- wr_data  in  NUM_QUEUES+KEY_WIDTH  {port, next hop}.
- wr_valid  in  1  entry valid.

Function
REQ-009 SHALL store per entry: key, mask, data, valid, and prefix length PLEN = popcount(wr_mask), computed at write time.
REQ-010 SHALL match an entry when valid=1 and (lookup_key & mask) == (key & mask).
REQ-011 SHALL select, among matches, the largest PLEN; ties go to the lowest index.
REQ-012 SHALL run a 3-stage pipeline, with one lookup accepted per cycle and no backpressure:
- S1 registers the match vector.
- S2 registers the winner index, PLEN and hit.
- S3 registers the outputs.
- lookup_ack is asserted exactly 3 cycles after lookup_req, and results return in order.
REQ-013 SHALL drive the following on a miss: lookup_hit=0, lookup_port=DEFAULT_PORT, lookup_next_hop=lookup_key.
REQ-014 SHALL drive lookup_next_hop=lookup_key on a hit whose stored next hop is 0; otherwise it drives the stored next hop.
REQ-015 SHALL perform a write in one cycle and pulse wr_ack on the next cycle; S1 of a lookup in the same cycle sees the pre-write table.
REQ-016 SHALL pulse rd_ack 1 cycle after rd_req; a read concurrent with a write to the same address returns the pre-write contents.
REQ-017 SHALL treat a wr_mask of 0 with wr_valid=1 as a default route (PLEN 0, matches all keys).
REQ-018 SHALL ignore out-of-range rd_addr/wr_addr (>= LUT_DEPTH): no table change, ack still pulses, read returns zeros.

Reset
REQ-019 SHALL, while reset=1, clear all valid bits, hit counters, pipeline valids and ack outputs, and set lookup_hit=0, lookup_port=DEFAULT_PORT, lookup_next_hop=0.
REQ-020 SHALL drop lookups in flight when reset is asserted; no lookup_ack is produced for them.

Configuration
REQ-021 SHALL, when IP_LPM_HIT_CNT_EN is defined, keep a 32-bit saturating hit counter per entry:
- The counter increments at S3 for the winning entry.
- The counter clears when that entry is written; a write in the same cycle as an increment clears the counter.
REQ-022 SHALL, when IP_LPM_HIT_CNT_EN is undefined, have no counters and drive rd_hit_cnt=0.

Structure
REQ-023 SHALL place the following in shared package ip_lpm_pkg:
- the entry struct typedef (key, mask, data, valid, PLEN);
- the PLEN width constant;
- the log2 function.
REQ-024 SHALL implement the S2 longest-prefix priority selector as sub-module lpm_prio_sel.

Verification
REQ-025 SHALL have a bench cover the following directed scenarios:
- Single route: write idx3 key 0A000000 mask FF000000 data {01,0}, then look up 0A010203 -> 3 cycles later hit=1, port=01, next_hop=0A010203.
- Longest prefix: idx0 = 0A000000/FF000000 port 01; idx5 = 0A010000/FFFF0000 port 04; look up 0A010203 -> port=04. Equal-PLEN tie between idx2 and idx7 -> idx2 wins.
- Miss: look up C0A80001 on an empty table -> hit=0, port=DEFAULT_PORT, next_hop=C0A80001. Adding a mask=0 route at idx9 with port 10 -> hit=1, port=10.
- Back-to-back: 4 lookups on consecutive cycles with alternating hit/miss -> 4 in-order acks on consecutive cycles.
- Concurrency: a read and a write to idx3 in the same cycle -> rd returns old data, both acks next cycle. Reset asserted during 2 in-flight lookups -> no acks and all valids cleared.
- Counters (with IP_LPM_HIT_CNT_EN): 5 hits on idx3 -> rd_hit_cnt=5; rewriting idx3 -> 0.
